// File: rtl/sparc_exu_aluccgen.sv
`default_nettype none
// ============================================================================
// Module   : sparc_exu_aluccgen
// Brief    : EXU condition-code generator and CCR pipeline. Forms icc/xcc
//            (N,Z,V,C) from the E-stage adder outputs, carries them through
//            M and W with kill/flush qualification, commits them to the
//            architectural CCR at W, and offers a bypassed CC view to the IFU.
// Revision : 1.0 - initial release
// ============================================================================
module sparc_exu_aluccgen (
    input  logic        clk,
    input  logic        reset,
    input  logic        se,
    input  logic [63:0] adder_out,
    input  logic        alu_ecl_cout64_e_l,
    input  logic        alu_ecl_cout32_e,
    input  logic        alu_ecl_adderin2_63_e,
    input  logic        alu_ecl_adderin2_31_e,
    input  logic        byp_alu_rs1_data_e_63,
    input  logic        byp_alu_rs1_data_e_31,
    input  logic        ifu_exu_invert_e,
    input  logic        ifu_exu_setcc_e,
    input  logic        ecl_kill_m,
    input  logic        ifu_exu_flush_w,
    input  logic        ecl_wrccr_w,
    input  logic [7:0]  ecl_wrccr_data_w,
    output logic [7:0]  exu_ccr_w,
    output logic [7:0]  exu_ifu_cc_d,
    output logic        exu_ifu_cc_vld_m
);

    // Reset value of every CC-holding register.
    localparam logic [7:0] C_CC_RESET = 8'h00;

    // Scan enable is carried for port compatibility only.
    logic w_unused_se;
    assign w_unused_se = se;

    // ------------------------------------------------------------------------
    // E stage: condition codes from the adder result
    // ------------------------------------------------------------------------
    logic       w_icc_n, w_icc_z, w_icc_v, w_icc_c;
    logic       w_xcc_n, w_xcc_z, w_xcc_v, w_xcc_c;
    logic [7:0] w_cc_e;

    // Overflow: operands agree in sign (after subtract inversion) but the
    // result sign differs. Carry is inverted for subtract so C means borrow.
    always_comb begin
        w_icc_n = adder_out[31];
        w_icc_z = (adder_out[31:0] == 32'h0000_0000);
        w_icc_v = (byp_alu_rs1_data_e_31 == alu_ecl_adderin2_31_e) &
                  (adder_out[31] != byp_alu_rs1_data_e_31);
        w_icc_c = alu_ecl_cout32_e ^ ifu_exu_invert_e;

        w_xcc_n = adder_out[63];
        w_xcc_z = (adder_out == 64'h0000_0000_0000_0000);
        w_xcc_v = (byp_alu_rs1_data_e_63 == alu_ecl_adderin2_63_e) &
                  (adder_out[63] != byp_alu_rs1_data_e_63);
        w_xcc_c = ~alu_ecl_cout64_e_l ^ ifu_exu_invert_e;

        w_cc_e  = {w_xcc_n, w_xcc_z, w_xcc_v, w_xcc_c,
                   w_icc_n, w_icc_z, w_icc_v, w_icc_c};
    end

    // ------------------------------------------------------------------------
    // Pipeline registers and architectural CCR
    // ------------------------------------------------------------------------
    logic [7:0] r_cc_m;
    logic       r_vld_m;
    logic [7:0] r_cc_w;
    logic       r_vld_w;
    logic [7:0] r_ccr;

    logic       w_vld_m_live;   // M-stage op writes CC and is not killed
    logic       w_vld_w_live;   // W-stage op writes CC and is not flushed

    assign w_vld_m_live = r_vld_m & ~ecl_kill_m;
    assign w_vld_w_live = r_vld_w & ~ifu_exu_flush_w;

    // E->M capture: CC data loads every cycle, the valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cc_m  <= C_CC_RESET;
            r_vld_m <= 1'b0;
        end else begin
            r_cc_m  <= w_cc_e;
            r_vld_m <= ifu_exu_setcc_e;
        end
    end

    // M->W advance: a kill in M drops the op's valid bit on its way to W.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cc_w  <= C_CC_RESET;
            r_vld_w <= 1'b0;
        end else begin
            r_cc_w  <= r_cc_m;
            r_vld_w <= w_vld_m_live;
        end
    end

    // W commit: WRCCR outranks a pipeline result; flushed ops never commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ccr <= C_CC_RESET;
        end else if (ecl_wrccr_w) begin
            r_ccr <= ecl_wrccr_data_w;
        end else if (w_vld_w_live) begin
            r_ccr <= r_cc_w;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // IFU bypass: youngest live in-flight CC wins, then a pending WRCCR,
    // then the committed CCR.
    always_comb begin
        exu_ifu_cc_d = r_ccr;
        if (w_vld_m_live) begin
            exu_ifu_cc_d = r_cc_m;
        end else if (w_vld_w_live) begin
            exu_ifu_cc_d = r_cc_w;
        end else if (ecl_wrccr_w) begin
            exu_ifu_cc_d = ecl_wrccr_data_w;
        end
    end

    assign exu_ccr_w        = r_ccr;
    assign exu_ifu_cc_vld_m = w_vld_m_live;

endmodule
`default_nettype wire

// File: tb/tb_sparc_exu_aluccgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sparc_exu_aluccgen
// Brief    : Self-checking bench for sparc_exu_aluccgen. Plays the adder,
//            derives flags from signed/unsigned arithmetic on the operands,
//            and predicts the bypass/CCR from a per-cycle event timeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sparc_exu_aluccgen;

    localparam int NCYC = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        se;
    logic [63:0] adder_out;
    logic        alu_ecl_cout64_e_l;
    logic        alu_ecl_cout32_e;
    logic        alu_ecl_adderin2_63_e;
    logic        alu_ecl_adderin2_31_e;
    logic        byp_alu_rs1_data_e_63;
    logic        byp_alu_rs1_data_e_31;
    logic        ifu_exu_invert_e;
    logic        ifu_exu_setcc_e;
    logic        ecl_kill_m;
    logic        ifu_exu_flush_w;
    logic        ecl_wrccr_w;
    logic [7:0]  ecl_wrccr_data_w;
    logic [7:0]  exu_ccr_w;
    logic [7:0]  exu_ifu_cc_d;
    logic        exu_ifu_cc_vld_m;

    sparc_exu_aluccgen dut (
        .clk                   (clk),
        .reset                 (reset),
        .se                    (se),
        .adder_out             (adder_out),
        .alu_ecl_cout64_e_l    (alu_ecl_cout64_e_l),
        .alu_ecl_cout32_e      (alu_ecl_cout32_e),
        .alu_ecl_adderin2_63_e (alu_ecl_adderin2_63_e),
        .alu_ecl_adderin2_31_e (alu_ecl_adderin2_31_e),
        .byp_alu_rs1_data_e_63 (byp_alu_rs1_data_e_63),
        .byp_alu_rs1_data_e_31 (byp_alu_rs1_data_e_31),
        .ifu_exu_invert_e      (ifu_exu_invert_e),
        .ifu_exu_setcc_e       (ifu_exu_setcc_e),
        .ecl_kill_m            (ecl_kill_m),
        .ifu_exu_flush_w       (ifu_exu_flush_w),
        .ecl_wrccr_w           (ecl_wrccr_w),
        .ecl_wrccr_data_w      (ecl_wrccr_data_w),
        .exu_ccr_w             (exu_ccr_w),
        .exu_ifu_cc_d          (exu_ifu_cc_d),
        .exu_ifu_cc_vld_m      (exu_ifu_cc_vld_m)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Stimulus for the current cycle
    logic [63:0] st_a, st_b;
    logic        st_sub, st_set, st_kill, st_flush, st_wr, st_rst;
    logic [7:0]  st_wd;

    // Event timeline: what was presented in each cycle
    logic [7:0] tl_cc   [0:NCYC-1];
    logic       tl_set  [0:NCYC-1];
    logic       tl_kill [0:NCYC-1];
    logic       tl_flush[0:NCYC-1];
    logic       tl_wr   [0:NCYC-1];
    logic       tl_rst  [0:NCYC-1];
    logic [7:0] tl_wd   [0:NCYC-1];
    logic [7:0] tl_ccr  [0:NCYC];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Architectural flags of a+b or a-b, from plain signed/unsigned arithmetic.
    function automatic logic [7:0] ref_cc(input logic [63:0] a, input logic [63:0] b, input logic sub);
        logic [63:0]        r;
        logic signed [32:0] s32;
        logic signed [64:0] s64;
        logic [32:0]        u32;
        logic [64:0]        u64;
        logic               iv, ic, xv, xc;
        r = sub ? a - b : a + b;
        if (sub) begin
            s32 = $signed({a[31], a[31:0]}) - $signed({b[31], b[31:0]});
            s64 = $signed({a[63], a}) - $signed({b[63], b});
            ic  = (a[31:0] < b[31:0]);
            xc  = (a < b);
        end else begin
            s32 = $signed({a[31], a[31:0]}) + $signed({b[31], b[31:0]});
            s64 = $signed({a[63], a}) + $signed({b[63], b});
            u32 = {1'b0, a[31:0]} + {1'b0, b[31:0]};
            u64 = {1'b0, a} + {1'b0, b};
            ic  = u32[32];
            xc  = u64[64];
        end
        iv = (s32[32] != s32[31]);
        xv = (s64[64] != s64[63]);
        return {r[63], (r == 64'd0), xv, xc, r[31], (r[31:0] == 32'd0), iv, ic};
    endfunction

    // Apply this cycle's stimulus, check at mid-cycle, advance to next cycle.
    task automatic cycle();
        logic [63:0] in2;
        logic [64:0] s65;
        logic [32:0] s33;
        logic        alive_m, alive_w, vexp;
        logic [7:0]  bexp;
        in2 = st_sub ? ~st_b : st_b;
        s65 = {1'b0, st_a} + {1'b0, in2} + {64'd0, st_sub};
        s33 = {1'b0, st_a[31:0]} + {1'b0, in2[31:0]} + {32'd0, st_sub};
        reset                 = st_rst;
        adder_out             = s65[63:0];
        alu_ecl_cout64_e_l    = ~s65[64];
        alu_ecl_cout32_e      = s33[32];
        alu_ecl_adderin2_63_e = in2[63];
        alu_ecl_adderin2_31_e = in2[31];
        byp_alu_rs1_data_e_63 = st_a[63];
        byp_alu_rs1_data_e_31 = st_a[31];
        ifu_exu_invert_e      = st_sub;
        ifu_exu_setcc_e       = st_set;
        ecl_kill_m            = st_kill;
        ifu_exu_flush_w       = st_flush;
        ecl_wrccr_w           = st_wr;
        ecl_wrccr_data_w      = st_wd;
        se                    = cyc[0];
        tl_cc[cyc]    = ref_cc(st_a, st_b, st_sub);
        tl_set[cyc]   = st_set;
        tl_kill[cyc]  = st_kill;
        tl_flush[cyc] = st_flush;
        tl_wr[cyc]    = st_wr;
        tl_rst[cyc]   = st_rst;
        tl_wd[cyc]    = st_wd;
        // Op issued one cycle ago sits in M; two cycles ago sits in W.
        alive_m = (cyc >= 1) && tl_set[cyc-1] && !tl_rst[cyc-1];
        alive_w = (cyc >= 2) && tl_set[cyc-2] && !tl_rst[cyc-2] && !tl_rst[cyc-1]
                  && !tl_kill[cyc-1] && !tl_flush[cyc];
        vexp = alive_m && !tl_kill[cyc];
        if (vexp)          bexp = tl_cc[cyc-1];
        else if (alive_w)  bexp = tl_cc[cyc-2];
        else if (tl_wr[cyc]) bexp = tl_wd[cyc];
        else               bexp = tl_ccr[cyc];
        #4;
        if (cyc >= 1) begin
            chk("ccr", exu_ccr_w, tl_ccr[cyc]);
            chk("cc_d", exu_ifu_cc_d, bexp);
            chk("vld_m", {7'd0, exu_ifu_cc_vld_m}, {7'd0, vexp});
        end
        if (tl_rst[cyc])       tl_ccr[cyc+1] = 8'h00;
        else if (tl_wr[cyc])   tl_ccr[cyc+1] = tl_wd[cyc];
        else if (alive_w)      tl_ccr[cyc+1] = tl_cc[cyc-2];
        else                   tl_ccr[cyc+1] = tl_ccr[cyc];
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        st_a = 64'd0; st_b = 64'd0; st_sub = 1'b0; st_set = 1'b0;
        st_kill = 1'b0; st_flush = 1'b0; st_wr = 1'b0; st_rst = 1'b0; st_wd = 8'h00;
    endtask

    task automatic op(input logic [63:0] a, input logic [63:0] b, input logic sub);
        idle();
        st_a = a; st_b = b; st_sub = sub; st_set = 1'b1;
    endtask

    function automatic logic [63:0] pick64();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0: v = 64'd0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'h0000_0000_7FFF_FFFF;
            3: v = 64'h8000_0000_0000_0000;
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    initial begin
        tl_ccr[0] = 8'hxx;
        idle();
        st_rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset then idle
        cycle(); cycle();
        idle();
        cycle(); cycle(); cycle();
        chk("reset_ccr", exu_ccr_w, 8'h00);
        chk("reset_cc_d", exu_ifu_cc_d, 8'h00);
        chk("reset_vld", {7'd0, exu_ifu_cc_vld_m}, 8'h00);

        // ADDcc 0x7FFFFFFF + 1
        op(64'h0000_0000_7FFF_FFFF, 64'd1, 1'b0);
        cycle();
        chk("addcc_byp", exu_ifu_cc_d, 8'h0A);
        idle(); cycle(); cycle();
        chk("addcc_ccr", exu_ccr_w, 8'h0A);

        // SUBcc 0 - 1
        op(64'd0, 64'd1, 1'b1);
        cycle(); idle(); cycle(); cycle();
        chk("sub_0m1_ccr", exu_ccr_w, 8'h99);

        // SUBcc 5 - 5
        op(64'd5, 64'd5, 1'b1);
        cycle(); idle(); cycle(); cycle();
        chk("sub_5m5_ccr", exu_ccr_w, 8'h44);

        // ADDcc giving 0x44, then SUBcc 0 - 1 killed in M
        op(64'd0, 64'd0, 1'b0);
        cycle();
        op(64'd0, 64'd1, 1'b1);
        cycle();
        chk("kill_byp_live", exu_ifu_cc_d, 8'h99);
        idle(); st_kill = 1'b1;
        cycle();
        idle(); cycle(); cycle();
        chk("kill_ccr", exu_ccr_w, 8'h44);

        // Flushed op in W never commits
        op(64'h0000_0000_7FFF_FFFF, 64'd1, 1'b0);
        cycle(); idle(); cycle();
        st_flush = 1'b1;
        cycle(); idle(); cycle();
        chk("flush_ccr", exu_ccr_w, 8'h44);

        // WRCCR outranks a valid op in W
        op(64'd0, 64'd1, 1'b1);
        cycle(); idle(); cycle();
        st_wr = 1'b1; st_wd = 8'h5A;
        cycle(); idle(); cycle();
        chk("wrccr_ccr", exu_ccr_w, 8'h5A);

        // Reset mid-flight discards in-flight CC
        op(64'd0, 64'd1, 1'b1);
        cycle();
        idle(); st_rst = 1'b1;
        cycle(); idle(); cycle(); cycle();
        chk("midreset_ccr", exu_ccr_w, 8'h00);

        // Randomized traffic against the timeline model
        for (int i = 0; i < 400; i++) begin
            idle();
            st_a     = pick64();
            st_b     = pick64();
            st_sub   = 1'($urandom_range(0, 1));
            st_set   = ($urandom_range(0, 3) != 0);
            st_kill  = ($urandom_range(0, 5) == 0);
            st_flush = ($urandom_range(0, 5) == 0);
            st_wr    = ($urandom_range(0, 7) == 0);
            st_wd    = 8'($urandom());
            st_rst   = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
